// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and helpers for the instruction-memory boot loader.
//   loader_state_e : frame-parser states
//   LEN_BYTES      : number of length bytes at the head of a frame
//   BYTES_PER_WORD : bytes per instruction word
//   LEN_W          : width of the word-count field (and of the word index)
//   word_addr()    : byte address of word idx relative to a base address
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } loader_state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = LEN_BYTES * 8;

  // The index is widened to the full 64-bit address before scaling, so
  // large indices never wrap inside a narrower intermediate.
  function automatic logic [63:0] word_addr(input logic [63:0]      base,
                                            input logic [LEN_W-1:0] idx);
    logic [63:0] w_idx_wide;
    w_idx_wide = {{(64-LEN_W){1'b0}}, idx};
    return base + (w_idx_wide * 64'(BYTES_PER_WORD));
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// -----------------------------------------------------------------------------
// byte_word_assembler
// Collects four accepted bytes (LSB first) into one 32-bit little-endian word.
//   i_clk        : clock
//   i_rst_n      : asynchronous active-low reset
//   i_clear      : synchronous clear of the byte counter and partial word
//   i_byte       : incoming byte
//   i_valid      : i_byte is accepted this cycle
//   o_word_valid : the accepted byte completes a word (combinational)
//   o_word       : the completed word, valid together with o_word_valid
// -----------------------------------------------------------------------------
module byte_word_assembler (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  // Only the three earlier bytes need storage; the fourth is taken straight
  // from i_byte, so the full 32-bit word is {i_byte, r_shift}.
  logic [23:0] r_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_clear) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word_valid = i_valid & ~i_clear & (r_cnt == 2'd3);
  assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the CPU instruction memory. Parses a framed byte
// stream (LEN_LO, LEN_HI, N*4 data bytes, CHK), writes each assembled word to
// consecutive word addresses and releases the CPU only after the XOR checksum
// of the frame verifies.
//   i_clk        : clock, all state changes on the rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_start      : one-cycle pulse, aborts any load and starts a new frame
//   i_byte       : stream data
//   i_byte_valid : i_byte is valid this cycle
//   o_byte_ready : loader can accept a byte (transfer = valid & ready)
//   o_imem_we    : imem write strobe, one cycle per word
//   o_imem_addr  : imem byte address (word aligned)
//   o_imem_wdata : instruction word
//   o_cpu_reset  : active-high reset to the CPU
//   o_done       : frame loaded and verified, CPU running
//   o_error      : frame rejected, CPU held in reset
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_reset,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  loader_state_e r_state, w_state_next;

  logic [LEN_W-1:0]  r_len,  w_len_next;
  logic [LEN_W-1:0]  r_idx,  w_idx_next;
  logic [7:0]        r_xor,  w_xor_next;
  logic              r_we,   w_we_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [31:0]       r_wdata, w_wdata_next;
  logic              r_cpu_reset, w_cpu_reset_next;
  logic              r_done, w_done_next;
  logic              r_error, w_error_next;
  logic              r_byte_ready, w_byte_ready_next;

  logic              w_fire;
  logic              w_take;
  logic              w_asm_valid;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [LEN_W-1:0]  w_len_full;

  assign w_fire      = i_byte_valid & r_byte_ready;
  // start wins over a byte offered in the same cycle: the byte is dropped.
  assign w_take      = w_fire & ~i_start;
  assign w_asm_valid = w_take & (r_state == S_DATA);
  assign w_len_full  = {i_byte, r_len[7:0]};

  byte_word_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (i_start),
    .i_byte       (i_byte),
    .i_valid      (w_asm_valid),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_LEN_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    w_state_next     = r_state;
    w_len_next       = r_len;
    w_idx_next       = r_idx;
    w_xor_next       = r_xor;
    w_we_next        = 1'b0;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_cpu_reset_next = r_cpu_reset;
    w_done_next      = r_done;
    w_error_next     = r_error;

    if (i_start) begin
      w_state_next     = S_LEN_LO;
      w_len_next       = '0;
      w_idx_next       = '0;
      w_xor_next       = 8'd0;
      w_cpu_reset_next = 1'b1;
      w_done_next      = 1'b0;
      w_error_next     = 1'b0;
    end else if (w_take) begin
      // The checksum byte itself is not folded into the running XOR.
      if (r_state != S_CHECK) begin
        w_xor_next = r_xor ^ i_byte;
      end

      case (r_state)
        S_LEN_LO: begin
          w_len_next   = {{(LEN_W-8){1'b0}}, i_byte};
          w_state_next = S_LEN_HI;
        end

        S_LEN_HI: begin
          w_len_next = w_len_full;
          w_idx_next = '0;
          if (w_len_full == '0) begin
            w_state_next = S_CHECK;
          end else if (32'(w_len_full) > DEPTH_U) begin
            w_state_next     = S_ERR;
            w_error_next     = 1'b1;
            w_cpu_reset_next = 1'b1;
          end else begin
            w_state_next = S_DATA;
          end
        end

        S_DATA: begin
          if (w_word_valid) begin
            w_we_next    = 1'b1;
            w_addr_next  = ADDR_W'(word_addr(64'(BASE_ADDR), r_idx));
            w_wdata_next = w_word;
            w_idx_next   = r_idx + 1'b1;
            if ((r_idx + 1'b1) == r_len) begin
              w_state_next = S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (i_byte == r_xor) begin
            w_state_next     = S_DONE;
            w_done_next      = 1'b1;
            w_cpu_reset_next = 1'b0;
          end else begin
            w_state_next     = S_ERR;
            w_error_next     = 1'b1;
            w_cpu_reset_next = 1'b1;
          end
        end

        default: begin
        end
      endcase
    end

    // Ready is registered from the next state so it stays low during reset
    // and rises on the first clock after release.
    w_byte_ready_next = (w_state_next != S_DONE) && (w_state_next != S_ERR);
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len        <= '0;
      r_idx        <= '0;
      r_xor        <= 8'd0;
      r_we         <= 1'b0;
      r_addr       <= BASE_ADDR;
      r_wdata      <= 32'd0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_byte_ready <= 1'b0;
    end else begin
      r_len        <= w_len_next;
      r_idx        <= w_idx_next;
      r_xor        <= w_xor_next;
      r_we         <= w_we_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
      r_cpu_reset  <= w_cpu_reset_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
      r_byte_ready <= w_byte_ready_next;
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h0;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic        o_imem_we;
  logic [63:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_reset;
  logic        o_done;
  logic        o_error;

  always #5 i_clk = ~i_clk;

  imem_loader #(.ADDR_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_reset  (o_cpu_reset),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  frame_q[$];
  logic [95:0] wr_q[$];
  logic [95:0] exp_q[$];
  logic        exp_done;
  logic        exp_err;

  // Write monitor: records every strobe as {addr, data}.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_imem_we === 1'b1) begin
      wr_q.push_back({o_imem_addr, o_imem_wdata});
    end
  end

  // ---------------- reference model ----------------
  // Frame-level interpretation: parse the word count, compute the expected
  // writes and whether the trailing checksum byte matches.
  task automatic build_expect();
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = int'({frame_q[1], frame_q[0]});
    if (n > DEPTH) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ frame_q[i];
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({BASE + 64'(4 * w), frame_q[2+4*w+3], frame_q[2+4*w+2],
                       frame_q[2+4*w+1], frame_q[2+4*w]});
    end
    exp_done = (frame_q[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  task automatic make_frame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n & 255));
    frame_q.push_back(8'((n >> 8) & 255));
    if (n > DEPTH) return;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
    end
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    if (corrupt) x = x ^ (8'h01 << $urandom_range(0, 7));
    frame_q.push_back(x);
  endtask

  task automatic load_happy(input logic [7:0] last);
    frame_q = '{8'h02, 8'h00, 8'h21, 8'h04, 8'h00, 8'h91,
                8'h00, 8'h00, 8'h00, 8'h14, last};
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    while (o_byte_ready !== 1'b1 && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (o_byte_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout: ready=%b required 1", o_byte_ready);
      i_byte_valid = 1'b0;
      return;
    end
    @(posedge i_clk); #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      send_byte(frame_q[i]);
      repeat (gap) begin @(posedge i_clk); #1; end
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) begin @(posedge i_clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #1;
    total++; if (o_imem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", o_imem_we); end
    total++; if (o_imem_addr !== BASE) begin bad++; $display("FAIL reset_addr: got %h want %h", o_imem_addr, BASE); end
    total++; if (o_imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", o_imem_wdata); end
    total++; if (o_cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset: got %b want 1", o_cpu_reset); end
    total++; if (o_done !== 1'b0 || o_error !== 1'b0) begin bad++; $display("FAIL reset_flags: done=%b error=%b want 0 0", o_done, o_error); end
    total++; if (o_byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", o_byte_ready); end
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    #1;
    total++; if (o_byte_ready !== 1'b0) begin bad++; $display("FAIL ready_before_clk: got %b want 0", o_byte_ready); end
    @(posedge i_clk); #1;
    total++; if (o_byte_ready !== 1'b1) begin bad++; $display("FAIL ready_after_clk: got %b want 1", o_byte_ready); end
  endtask

  task automatic test_happy();
    load_happy(8'hA2);
    build_expect();
    wr_q.delete();
    send_range(0, 5, 0);
    total++; if (o_imem_we !== 1'b1) begin bad++; $display("FAIL happy_we_timing: got %b want 1", o_imem_we); end
    total++; if (o_imem_addr !== 64'h0 || o_imem_wdata !== 32'h91000421) begin bad++; $display("FAIL happy_word0: got %h/%h want 0/91000421", o_imem_addr, o_imem_wdata); end
    total++; if (o_cpu_reset !== 1'b1) begin bad++; $display("FAIL happy_cpu_held: got %b want 1", o_cpu_reset); end
    @(posedge i_clk); #1;
    total++; if (o_imem_we !== 1'b0) begin bad++; $display("FAIL happy_we_pulse: got %b want 0", o_imem_we); end
    send_range(6, 10, 0);
    total++; if (o_done !== 1'b1 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL happy_done_timing: done=%b cpu_reset=%b want 1 0", o_done, o_cpu_reset); end
    settle();
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL happy_nwrites: got %0d want 2", wr_q.size()); end
    total++; if (wr_q.size() > 1 && wr_q[1] !== {64'h4, 32'h14000000}) begin bad++; $display("FAIL happy_word1: got %h want 4/14000000", wr_q[1]); end
    total++; if (o_byte_ready !== 1'b0 || o_error !== 1'b0 || o_done !== 1'b1) begin bad++; $display("FAIL happy_final: ready=%b error=%b done=%b want 0 0 1", o_byte_ready, o_error, o_done); end
  endtask

  task automatic test_bad_chk();
    pulse_start();
    total++; if (o_done !== 1'b0 || o_cpu_reset !== 1'b1) begin bad++; $display("FAIL start_clears: done=%b cpu_reset=%b want 0 1", o_done, o_cpu_reset); end
    load_happy(8'hA3);
    build_expect();
    wr_q.delete();
    send_range(0, 10, 0);
    settle();
    total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL badchk_nwrites: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      total++; if (wr_q[k] !== exp_q[k]) begin bad++; $display("FAIL badchk_write%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
    end
    total++; if (o_error !== 1'b1 || o_done !== 1'b0 || o_cpu_reset !== 1'b1 || o_byte_ready !== 1'b0) begin bad++; $display("FAIL badchk_flags: error=%b done=%b cpu_reset=%b ready=%b want 1 0 1 0", o_error, o_done, o_cpu_reset, o_byte_ready); end
  endtask

  task automatic test_oversize();
    pulse_start();
    wr_q.delete();
    frame_q = '{8'h01, 8'h04};
    send_range(0, 1, 0);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL oversize_error_timing: got %b want 1", o_error); end
    settle();
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL oversize_writes: got %0d want 0", wr_q.size()); end
    total++; if (o_cpu_reset !== 1'b1 || o_byte_ready !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL oversize_flags: cpu_reset=%b ready=%b done=%b want 1 0 0", o_cpu_reset, o_byte_ready, o_done); end
  endtask

  task automatic test_empty();
    pulse_start();
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL start_clears_error: got %b want 0", o_error); end
    wr_q.delete();
    frame_q = '{8'h00, 8'h00, 8'h00};
    send_range(0, 2, 0);
    settle();
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL empty_writes: got %0d want 0", wr_q.size()); end
    total++; if (o_done !== 1'b1 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL empty_done: done=%b cpu_reset=%b want 1 0", o_done, o_cpu_reset); end
  endtask

  task automatic test_throttled();
    pulse_start();
    wr_q.delete();
    load_happy(8'hA2);
    build_expect();
    send_range(0, 10, 2);
    settle();
    total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL throttle_nwrites: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      total++; if (wr_q[k] !== exp_q[k]) begin bad++; $display("FAIL throttle_write%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
    end
    total++; if (o_done !== 1'b1 || o_error !== 1'b0) begin bad++; $display("FAIL throttle_done: done=%b error=%b want 1 0", o_done, o_error); end
  endtask

  task automatic test_abort();
    pulse_start();
    load_happy(8'hA2);
    send_range(0, 7, 0);
    // start together with an offered byte: the byte must be dropped.
    i_start      = 1'b1;
    i_byte       = 8'h55;
    i_byte_valid = 1'b1;
    @(posedge i_clk); #1;
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    wr_q.delete();
    build_expect();
    send_range(0, 10, 0);
    settle();
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL abort_nwrites: got %0d want 2", wr_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      total++; if (wr_q[k] !== exp_q[k]) begin bad++; $display("FAIL abort_write%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
    end
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL abort_done: got %b want 1", o_done); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    load_happy(8'hA2);
    send_range(0, 4, 0);
    #2 i_rst_n = 1'b0;
    #1;
    total++; if (o_byte_ready !== 1'b0 || o_cpu_reset !== 1'b1 || o_imem_we !== 1'b0) begin bad++; $display("FAIL arst_outputs: ready=%b cpu_reset=%b we=%b want 0 1 0", o_byte_ready, o_cpu_reset, o_imem_we); end
    total++; if (o_imem_addr !== BASE || o_done !== 1'b0) begin bad++; $display("FAIL arst_addr_done: addr=%h done=%b want %h 0", o_imem_addr, o_done, BASE); end
    repeat (2) @(posedge i_clk);
    #4 i_rst_n = 1'b1;
    wr_q.delete();
    @(posedge i_clk); #1;
    build_expect();
    send_range(0, 10, 0);
    settle();
    total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL arst_nwrites: got %0d want %0d", wr_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      total++; if (wr_q[k] !== exp_q[k]) begin bad++; $display("FAIL arst_write%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
    end
    total++; if (o_done !== 1'b1 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL arst_done: done=%b cpu_reset=%b want 1 0", o_done, o_cpu_reset); end
  endtask

  task automatic test_full_depth();
    pulse_start();
    wr_q.delete();
    make_frame(DEPTH, 1'b0);
    build_expect();
    send_range(0, frame_q.size() - 1, 0);
    settle();
    total++; if (wr_q.size() != DEPTH) begin bad++; $display("FAIL depth_nwrites: got %0d want %0d", wr_q.size(), DEPTH); end
    total++; if (wr_q.size() == DEPTH && wr_q[DEPTH-1] !== exp_q[DEPTH-1]) begin bad++; $display("FAIL depth_last: got %h want %h", wr_q[DEPTH-1], exp_q[DEPTH-1]); end
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL depth_done: got %b want 1", o_done); end
  endtask

  task automatic test_random();
    int n;
    int gap;
    bit corrupt;
    for (int it = 0; it < 12; it++) begin
      pulse_start();
      wr_q.delete();
      if ($urandom_range(0, 7) == 0) n = 1025 + int'($urandom_range(0, 3000));
      else n = int'($urandom_range(0, 6));
      corrupt = ($urandom_range(0, 3) == 0);
      gap = int'($urandom_range(0, 2));
      make_frame(n, corrupt);
      build_expect();
      send_range(0, frame_q.size() - 1, gap);
      settle();
      total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wr_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
        total++; if (wr_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand%0d_write%0d: got %h want %h", it, k, wr_q[k], exp_q[k]); end
      end
      total++; if (o_done !== exp_done || o_error !== exp_err || o_cpu_reset !== !exp_done) begin bad++; $display("FAIL rand%0d_flags: done=%b error=%b cpu_reset=%b want %b %b %b", it, o_done, o_error, o_cpu_reset, exp_done, exp_err, !exp_done); end
      total++; if (o_byte_ready !== 1'b0) begin bad++; $display("FAIL rand%0d_ready: got %b want 0", it, o_byte_ready); end
      $display("rand frame %0d: n=%0d corrupt=%0d gap=%0d writes=%0d", it, n, corrupt, gap, wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_bad_chk();
    test_oversize();
    test_empty();
    test_throttled();
    test_abort();
    test_async_reset();
    test_full_depth();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
